// File: rtl/pht_update_queue.sv
// Coalescing write queue between branch-resolution lanes and the single PHT write port.
// Circular buffer with in-place merge of same-index updates and a youngest-match lookup.
module pht_update_queue #(
  parameter int DEPTH          = 32,
  parameter int PUSH_PORTS     = 2,
  parameter int INDEX_WIDTH    = 10,
  parameter int VALUE_WIDTH    = 2,
  parameter int COALESCE       = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PUSH_PORTS-1:0]             pushValid,
  input  logic [PUSH_PORTS*INDEX_WIDTH-1:0] pushIndex,
  input  logic [PUSH_PORTS*VALUE_WIDTH-1:0] pushValue,
  output logic                              pushReady,
  input  logic                              drainReady,
  output logic                              drainValid,
  output logic [INDEX_WIDTH-1:0]            drainIndex,
  output logic [VALUE_WIDTH-1:0]            drainValue,
  input  logic [INDEX_WIDTH-1:0]            lookupIndex,
  output logic                              lookupHit,
  output logic [VALUE_WIDTH-1:0]            lookupValue,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [DROP_CNT_WIDTH-1:0]         dropCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DSW   = DROP_CNT_WIDTH + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - PUSH_PORTS);

  logic [PTR_W-1:0]          head, tail;
  logic [CNT_W-1:0]          cnt;
  logic [DEPTH-1:0]          ent_valid;
  logic [INDEX_WIDTH-1:0]    ent_index [DEPTH];
  logic [VALUE_WIDTH-1:0]    ent_value [DEPTH];
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  logic                      drain_fire;
  logic [INDEX_WIDTH-1:0]    lane_index [PUSH_PORTS];
  logic [VALUE_WIDTH-1:0]    lane_value [PUSH_PORTS];
  logic [PUSH_PORTS-1:0]     lane_alloc, lane_ovr;
  logic [PTR_W-1:0]          lane_slot [PUSH_PORTS];
  logic [CNT_W-1:0]          alloc_num;
  logic [DSW-1:0]            drop_sum;

  assign pushReady  = (cnt <= READY_MAX);
  assign drainValid = (cnt != '0);
  assign drain_fire = drainValid & drainReady;
  assign drainIndex = drainValid ? ent_index[head] : '0;
  assign drainValue = drainValid ? ent_value[head] : '0;
  assign count      = cnt;
  assign dropCount  = drop_cnt;

  always_comb begin
    for (int i = 0; i < PUSH_PORTS; i++) begin
      lane_index[i] = pushIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
      lane_value[i] = pushValue[i*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

  // A lane is superseded when a higher lane carries the same index this cycle;
  // the head being drained is excluded from matching so its update is not lost.
  always_comb begin
    logic             superseded;
    logic             hit;
    logic [PTR_W-1:0] hit_slot;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    lane_alloc = '0;
    lane_ovr   = '0;
    alloc_num  = '0;
    superseded = 1'b0;
    hit        = 1'b0;
    hit_slot   = '0;
    for (int i = 0; i < PUSH_PORTS; i++) lane_slot[i] = '0;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      superseded = 1'b0;
      hit        = 1'b0;
      hit_slot   = '0;
      if (COALESCE != 0) begin
        for (int k = i + 1; k < PUSH_PORTS; k++)
          if (pushValid[k] && (lane_index[k] == lane_index[i])) superseded = 1'b1;
        for (int j = 0; j < DEPTH; j++)
          if (ent_valid[j] && (ent_index[j] == lane_index[i]) &&
              !(drain_fire && (PTR_W'(j) == head))) begin
            hit      = 1'b1;
            hit_slot = PTR_W'(j);
          end
      end
      if (pushReady && pushValid[i] && !superseded) begin
        if (hit) begin
          lane_ovr[i]  = 1'b1;
          lane_slot[i] = hit_slot;
        end else begin
          lane_alloc[i] = 1'b1;
          lane_slot[i]  = tail + alloc_num[PTR_W-1:0];
          alloc_num     = alloc_num + CNT_W'(1);
        end
      end
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] p;
    lookupHit   = 1'b0;
    lookupValue = '0;
    p           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PTR_W'(k);
      if (ent_valid[p] && (ent_index[p] == lookupIndex)) begin
        lookupHit   = 1'b1;
        lookupValue = ent_value[p];
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + DSW'($countones(pushValid));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ent_valid <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drain_fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      for (int i = 0; i < PUSH_PORTS; i++)
        if (lane_alloc[i]) ent_valid[lane_slot[i]] <= 1'b1;
      tail <= tail + alloc_num[PTR_W-1:0];
      cnt  <= cnt + alloc_num - CNT_W'(drain_fire);
      if (!pushReady)
        drop_cnt <= drop_sum[DSW-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  // NOTE: payload storage is not reset; valid bits gate every read of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_PORTS; i++) begin
      if (lane_alloc[i]) ent_index[lane_slot[i]] <= lane_index[i];
      if (lane_alloc[i] || lane_ovr[i]) ent_value[lane_slot[i]] <= lane_value[i];
    end
  end

endmodule

// File: tb/tb_pht_update_queue.sv
// Directed and model-checked bench for pht_update_queue (DEPTH 32, two lanes),
// with a second non-coalescing instance sharing the same stimulus.
module tb_pht_update_queue;

  localparam int DEPTH = 32;
  localparam int IW    = 10;
  localparam int VW    = 2;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    pushValid;
  logic [2*IW-1:0] pushIndex;
  logic [2*VW-1:0] pushValue;
  logic          drainReady;
  logic [IW-1:0] lookupIndex;

  logic          pushReady, drainValid, lookupHit;
  logic [IW-1:0] drainIndex;
  logic [VW-1:0] drainValue, lookupValue;
  logic [CW-1:0] count;
  logic [DW-1:0] dropCount;

  logic          nc_pushReady, nc_drainValid, nc_lookupHit;
  logic [IW-1:0] nc_drainIndex;
  logic [VW-1:0] nc_drainValue, nc_lookupValue;
  logic [CW-1:0] nc_count;
  logic [DW-1:0] nc_dropCount;

  int checks = 0;
  int errors = 0;

  pht_update_queue #(.DEPTH(DEPTH), .PUSH_PORTS(2), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
                     .COALESCE(1), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .pushValid(pushValid), .pushIndex(pushIndex),
    .pushValue(pushValue), .pushReady(pushReady), .drainReady(drainReady),
    .drainValid(drainValid), .drainIndex(drainIndex), .drainValue(drainValue),
    .lookupIndex(lookupIndex), .lookupHit(lookupHit), .lookupValue(lookupValue),
    .count(count), .dropCount(dropCount));

  pht_update_queue #(.DEPTH(DEPTH), .PUSH_PORTS(2), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
                     .COALESCE(0), .DROP_CNT_WIDTH(DW)) dut_nc (
    .clk(clk), .rst(rst), .pushValid(pushValid), .pushIndex(pushIndex),
    .pushValue(pushValue), .pushReady(nc_pushReady), .drainReady(drainReady),
    .drainValid(nc_drainValid), .drainIndex(nc_drainIndex), .drainValue(nc_drainValue),
    .lookupIndex(lookupIndex), .lookupHit(nc_lookupHit), .lookupValue(nc_lookupValue),
    .count(nc_count), .dropCount(nc_dropCount));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] pv, input int i0, input int v0, input int i1,
                       input int v1, input logic dr, input int li);
    pushValid   = pv;
    pushIndex   = {IW'(i1), IW'(i0)};
    pushValue   = {VW'(v1), VW'(v0)};
    drainReady  = dr;
    lookupIndex = IW'(li);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // Each row: inputs for one cycle and the outputs expected in that same cycle.
  typedef struct {
    logic [1:0] pv;
    int i0, v0, i1, v1;
    logic dr;
    int li;
    int cnt;
    logic dv;
    int di, dval;
    logic lh;
    int lv;
  } vec_t;

  vec_t vecs[$];

  int qi[$];
  int qv[$];

  initial begin
    rst = 1'b0;
    do_reset();

    // Idle state after reset.
    @(negedge clk);
    check("rst count", count, 0);
    check("rst pushReady", pushReady, 1);
    check("rst drainValid", drainValid, 0);
    check("rst dropCount", dropCount, 0);
    check("rst lookupHit", lookupHit, 0);
    check("rst drainIndex", drainIndex, 0);
    check("rst drainValue", drainValue, 0);
    check("rst lookupValue", lookupValue, 0);
    tick();

    //           pv     i0 v0 i1 v1 dr li | cnt dv di dval lh lv
    // basic FIFO
    vecs.push_back('{2'b11,  3, 2, 7, 1, 0,  3,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  7,  2, 1, 3, 2, 1, 1});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  3,  2, 1, 3, 2, 1, 2});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  3,  1, 1, 7, 1, 0, 0});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  7,  0, 0, 0, 0, 0, 0});
    // coalescing across cycles
    vecs.push_back('{2'b01,  5, 1, 0, 0, 0,  5,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b01,  5, 3, 0, 0, 0,  5,  1, 1, 5, 1, 1, 1});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  5,  1, 1, 5, 3, 1, 3});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  5,  1, 1, 5, 3, 1, 3});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  5,  0, 0, 0, 0, 0, 0});
    // same-cycle lanes, highest lane wins
    vecs.push_back('{2'b11,  9, 0, 9, 2, 0,  9,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  9,  1, 1, 9, 2, 1, 2});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  9,  1, 1, 9, 2, 1, 2});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  9,  0, 0, 0, 0, 0, 0});
    // head race: push to the draining head's index allocates a new entry
    vecs.push_back('{2'b01,  4, 1, 0, 0, 0,  4,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b01,  4, 3, 0, 0, 1,  4,  1, 1, 4, 1, 1, 1});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  4,  1, 1, 4, 3, 1, 3});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1,  4,  1, 1, 4, 3, 1, 3});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0,  4,  0, 0, 0, 0, 0, 0});
    // lookup latency through push and drain
    vecs.push_back('{2'b01, 12, 2, 0, 0, 0, 12,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1, 12,  1, 1,12, 2, 1, 2});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0, 12,  0, 0, 0, 0, 0, 0});
    // overwrite a non-head entry while the head drains
    vecs.push_back('{2'b11, 20, 1,21, 2, 0, 21,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{2'b01, 21, 3, 0, 0, 1, 21,  2, 1,20, 1, 1, 2});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 1, 21,  1, 1,21, 3, 1, 3});
    vecs.push_back('{2'b00,  0, 0, 0, 0, 0, 21,  0, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].i0, vecs[i].v0, vecs[i].i1, vecs[i].v1, vecs[i].dr, vecs[i].li);
      @(negedge clk);
      check($sformatf("row%0d count", i), count, vecs[i].cnt);
      check($sformatf("row%0d drainValid", i), drainValid, vecs[i].dv);
      check($sformatf("row%0d drainIndex", i), drainIndex, vecs[i].di);
      check($sformatf("row%0d drainValue", i), drainValue, vecs[i].dval);
      check($sformatf("row%0d lookupHit", i), lookupHit, vecs[i].lh);
      check($sformatf("row%0d lookupValue", i), lookupValue, vecs[i].lv);
      check($sformatf("row%0d pushReady", i), pushReady, 1);
      tick();
    end

    // Coalescing versus always-allocate on identical stimulus.
    do_reset();
    drive(2'b01, 5, 1, 0, 0, 1'b0, 0); tick();
    drive(2'b01, 5, 3, 0, 0, 1'b0, 0); tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    check("coal count", count, 1);
    check("nocoal count", nc_count, 2);
    tick();
    drive(2'b11, 9, 0, 9, 2, 1'b0, 0); tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    check("coal lanes count", count, 2);
    check("nocoal lanes count", nc_count, 4);
    tick();

    // Asynchronous reset in the middle of a drain.
    do_reset();
    drive(2'b11, 30, 1, 31, 2, 1'b0, 0); tick();
    drive(2'b11, 32, 3, 33, 0, 1'b0, 0); tick();
    drive(2'b01, 34, 1, 0, 0, 1'b0, 0);  tick();
    drive(2'b00, 0, 0, 0, 0, 1'b1, 30);
    @(negedge clk);
    check("pre-reset count", count, 5);
    rst = 1'b0;
    #1;
    check("async rst count", count, 0);
    check("async rst drainValid", drainValid, 0);
    check("async rst lookupHit", lookupHit, 0);
    check("async rst pushReady", pushReady, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post-reset count", count, 0);

    // Fill to 31, then drops and saturation of the drop counter.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 2*k, 1, 2*k+1, 2, 1'b0, 0);
      tick();
    end
    drive(2'b01, 40, 3, 0, 0, 1'b0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 1'b0, 200);
    check("full count", count, 31);
    check("full pushReady", pushReady, 0);
    drive(2'b11, 200, 1, 201, 2, 1'b0, 200);
    tick();
    check("drop dropCount", dropCount, 2);
    check("drop count", count, 31);
    check("drop lookupHit", lookupHit, 0);
    for (int k = 0; k < 32766; k++) tick();
    check("drop near-sat", dropCount, 16'hFFFE);
    tick();
    check("drop saturate", dropCount, 16'hFFFF);
    drive(2'b01, 202, 1, 0, 0, 1'b0, 0);
    tick();
    check("drop stays sat", dropCount, 16'hFFFF);
    check("drop sat count", count, 31);

    // Random drain pressure against a reference queue, across pointer wrap.
    do_reset();
    begin
      int pushes = 0;
      int cyc = 0;
      int allocs = 0;
      while (pushes < 100 && cyc < 1000) begin
        int idx, val, lane, j, exp_lv;
        logic dr, exp_lh, drn, rdy;
        idx  = $urandom_range(0, 15);
        val  = $urandom_range(0, 3);
        lane = $urandom_range(0, 1);
        dr   = ($urandom_range(0, 3) != 0);
        if (lane == 0) drive(2'b01, idx, val, 0, 0, dr, idx);
        else           drive(2'b10, 0, 0, idx, val, dr, idx);
        exp_lh = 1'b0;
        exp_lv = 0;
        foreach (qi[k]) if (qi[k] == idx) begin exp_lh = 1'b1; exp_lv = qv[k]; end
        @(negedge clk);
        check("rnd count", count, qi.size());
        check("rnd drainValid", drainValid, (qi.size() != 0));
        if (qi.size() != 0) begin
          check("rnd drainIndex", drainIndex, qi[0]);
          check("rnd drainValue", drainValue, qv[0]);
        end
        check("rnd lookupHit", lookupHit, exp_lh);
        check("rnd lookupValue", lookupValue, exp_lv);
        drn = (qi.size() != 0) && dr;
        rdy = ((DEPTH - qi.size()) >= 2);
        j = -1;
        for (int k = (drn ? 1 : 0); k < qi.size(); k++) if (qi[k] == idx) j = k;
        if (drn) begin
          void'(qi.pop_front());
          void'(qv.pop_front());
          if (j > 0) j--;
        end
        if (rdy) begin
          if (j >= 0) qv[j] = val;
          else begin qi.push_back(idx); qv.push_back(val); allocs++; end
        end
        pushes++;
        cyc++;
        tick();
      end
      drive(2'b00, 0, 0, 0, 0, 1'b1, 0);
      cyc = 0;
      while (qi.size() != 0 && cyc < 100) begin
        @(negedge clk);
        check("flush drainValid", drainValid, 1);
        check("flush drainIndex", drainIndex, qi[0]);
        check("flush drainValue", drainValue, qv[0]);
        void'(qi.pop_front());
        void'(qv.pop_front());
        cyc++;
        tick();
      end
      check("flush count", count, 0);
      check("flush drainValid end", drainValid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
